// File: rtl/adam_periph_uart_rx.sv
// UART receive stage: oversampled rx line -> valid/ready word with parity/frame/overrun pulses.
// Build option ADAM_UART_RX_MAJORITY_EN: each bit is a 2-of-3 vote around its centre.
//   state  | meaning
//   IDLE   | line idle, waiting for a start edge (held here while paused)
//   START  | timing to start-bit centre, rejects glitches
//   DATA   | shifting in data bits, LSB first
//   PARITY | checking the parity bit
//   STOP   | sampling the first stop bit; frame completes on that sample
module adam_periph_uart_rx #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pause_req,
    output logic                  pause_ack,
    input  logic                  parity_select,
    input  logic                  parity_control,
    input  logic [3:0]            data_length,
    input  logic [1:0]            stop_bits,
    input  logic [DATA_WIDTH-1:0] baud_rate,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  parity_error,
    output logic                  frame_error,
    output logic                  overrun_error,
    input  logic                  rx
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t r_state, w_state_nx;

    logic                  r_rx_m, r_rx_s;
    logic [DATA_WIDTH-1:0] r_period, r_bit_cnt, w_period;
    logic [3:0]            r_len, r_idx;
    logic                  r_par_en, r_par_sel, r_perr;
    logic [15:0]           r_word;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_pause_ack, r_valid, r_parity_error, r_frame_error, r_overrun;
    logic                  w_start, w_tick, w_sample, w_done, w_cnt_zero;
    logic                  w_unused;

    // Extra stop bits are idle level and IDLE absorbs them, so the field carries no information here.
    assign w_unused   = ^stop_bits;
    assign w_period   = (baud_rate < DATA_WIDTH'(4)) ? DATA_WIDTH'(4) : baud_rate;
    assign w_cnt_zero = (r_bit_cnt == '0);
    assign w_start    = (r_state == IDLE) && !r_rx_s && !r_pause_ack;
    assign w_done     = (r_state == STOP) && w_tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_rx_m <= rx;
            r_rx_s <= r_rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_period  <= DATA_WIDTH'(4);
            r_bit_cnt <= '0;
            r_len     <= '0;
            r_par_en  <= 1'b0;
            r_par_sel <= 1'b0;
        end else if (w_start) begin
            r_period  <= w_period;
            r_bit_cnt <= (w_period >> 1) - DATA_WIDTH'(1);
            r_len     <= data_length;
            r_par_en  <= parity_control;
            r_par_sel <= parity_select;
        end else if (r_state != IDLE) begin
            r_bit_cnt <= w_cnt_zero ? r_period - DATA_WIDTH'(1) : r_bit_cnt - DATA_WIDTH'(1);
        end
    end

`ifdef ADAM_UART_RX_MAJORITY_EN
    logic r_s1, r_s0, r_pend;

    // Votes on the samples at bit_cnt==1 and ==0 plus the current one, so the FSM acts a cycle late.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1   <= 1'b1;
            r_s0   <= 1'b1;
            r_pend <= 1'b0;
        end else begin
            if (r_bit_cnt == DATA_WIDTH'(1)) r_s1 <= r_rx_s;
            if (w_cnt_zero) r_s0 <= r_rx_s;
            r_pend <= (r_state != IDLE) && w_cnt_zero;
        end
    end

    assign w_tick   = r_pend;
    assign w_sample = (r_s1 & r_s0) | (r_s1 & r_rx_s) | (r_s0 & r_rx_s);
`else
    assign w_tick   = (r_state != IDLE) && w_cnt_zero;
    assign w_sample = r_rx_s;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:   if (w_start) w_state_nx = START;
            START:  if (w_tick) begin
                        if (w_sample)          w_state_nx = IDLE;
                        else if (r_len != '0)  w_state_nx = DATA;
                        else if (r_par_en)     w_state_nx = PARITY;
                        else                   w_state_nx = STOP;
                    end
            DATA:   if (w_tick && (r_idx == r_len - 4'd1))
                        w_state_nx = r_par_en ? PARITY : STOP;
            PARITY: if (w_tick) w_state_nx = STOP;
            STOP:   if (w_tick) w_state_nx = IDLE;
            default:            w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word         <= '0;
            r_idx          <= '0;
            r_perr         <= 1'b0;
            r_data         <= '0;
            r_valid        <= 1'b0;
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
            r_overrun      <= 1'b0;
            if (w_start) begin
                r_word <= '0;
                r_idx  <= '0;
                r_perr <= 1'b0;
            end
            if (w_tick && (r_state == DATA)) begin
                r_word[r_idx] <= w_sample;
                r_idx         <= r_idx + 4'd1;
            end
            if (w_tick && (r_state == PARITY))
                r_perr <= (w_sample != (^r_word ^ r_par_sel));
            if (w_done) begin
                r_parity_error <= r_perr;
                r_frame_error  <= !w_sample;
                if (!r_valid || data_ready) begin
                    r_data  <= DATA_WIDTH'(r_word);
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               r_pause_ack <= 1'b0;
        else if (!pause_req)                    r_pause_ack <= 1'b0;
        else if ((r_state == IDLE) && !w_start) r_pause_ack <= 1'b1;
    end

    assign pause_ack     = r_pause_ack;
    assign data          = r_data;
    assign data_valid    = r_valid;
    assign parity_error  = r_parity_error;
    assign frame_error   = r_frame_error;
    assign overrun_error = r_overrun;
endmodule

// File: tb/tb_adam_periph_uart_rx.sv
// Bench for adam_periph_uart_rx: directed frame table, hand sequences, randomized frames vs model.
`timescale 1ns/1ps
module tb_adam_periph_uart_rx;
    localparam int DW = 32;
`ifdef ADAM_UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic          clk = 1'b0, rst = 1'b0, pause_req = 1'b0;
    logic          parity_select = 1'b0, parity_control = 1'b1, data_ready = 1'b1, rx = 1'b1;
    logic [3:0]    data_length = 4'd8;
    logic [1:0]    stop_bits = 2'd1;
    logic [DW-1:0] baud_rate = 434;
    logic          pause_ack, data_valid, parity_error, frame_error, overrun_error;
    logic [DW-1:0] data;

    adam_periph_uart_rx #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(pause_ack),
        .parity_select(parity_select), .parity_control(parity_control),
        .data_length(data_length), .stop_bits(stop_bits), .baud_rate(baud_rate),
        .data(data), .data_valid(data_valid), .data_ready(data_ready),
        .parity_error(parity_error), .frame_error(frame_error),
        .overrun_error(overrun_error), .rx(rx)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
    } ev_t;
    ev_t evq[$];
    int  ovr_cnt = 0, ovr_cyc = -1, ack_cyc = -1, stray_cnt = 0;
    logic prev_valid = 1'b0, prev_ack = 1'b0;

    // Word arrivals are data_valid rises; error pulses must land on one (or on an overrun).
    always @(posedge clk) begin
        ev_t e;
        #1;
        if (data_valid && !prev_valid) begin
            e.cyc = cyc; e.data = data; e.perr = parity_error; e.ferr = frame_error;
            evq.push_back(e);
        end else if ((parity_error || frame_error) && !overrun_error) begin
            stray_cnt++;
        end
        if (overrun_error) begin ovr_cnt++; ovr_cyc = cyc; end
        if (pause_ack && !prev_ack) ack_cyc = cyc;
        prev_valid = data_valid;
        prev_ack   = pause_ack;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int period_of(input int baud);
        return (baud < 4) ? 4 : baud;
    endfunction

    // Serialises one frame; c0 is the cycle the start bit went onto the line.
    task automatic send_frame(input logic [15:0] d, input int len, input bit pe, input bit ps,
                              input bit flip, input bit bad_stop, input int sb, input int baud,
                              output int c0);
        bit bits[$];
        int b, ones;
        bit p;
        b = period_of(baud);
        @(posedge clk); #1;
        data_length = 4'(len); parity_control = pe; parity_select = ps;
        stop_bits = 2'(sb); baud_rate = DW'(baud);
        bits.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < len; i++) begin
            bits.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (pe) begin
            p = (((ones + (ps ? 1 : 0)) % 2) != 0);
            bits.push_back(p ^ flip);
        end
        bits.push_back(!bad_stop);
        for (int i = 0; i < sb; i++) bits.push_back(1'b1);
        c0 = cyc;
        foreach (bits[i]) begin
            rx = bits[i];
            repeat (b) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic expect_word(input string tag, input int c0, input int k, input int b,
                               input logic [DW-1:0] ed, input bit ep, input bit ef,
                               output int rc);
        ev_t e;
        int  w;
        w = 0; rc = -1;
        while (evq.size() == 0 && w < 4 * b + 40) begin
            @(posedge clk); #2; w++;
        end
        chk({tag, " arrived"}, 64'(evq.size() != 0), 64'(1));
        if (evq.size() != 0) begin
            e = evq.pop_front();
            rc = e.cyc;
            chk({tag, " data"}, 64'(e.data), 64'(ed));
            chk({tag, " parity_error"}, 64'(e.perr), 64'(ep));
            chk({tag, " frame_error"}, 64'(e.ferr), 64'(ef));
            chk({tag, " latency"}, 64'(e.cyc - c0), 64'(3 + b / 2 + k * b + MAJ));
        end
    endtask

    typedef struct {
        logic [15:0]   d;
        int            len;
        bit            pe, ps, flip, bad;
        int            sb, baud;
        logic [DW-1:0] ed;
        bit            ep, ef;
    } vec_t;
    vec_t vt[8];

    initial begin
        #(95_000 * 20);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, rc, b, w, len;
        bit pe, flip, bad;
        logic [15:0] d;

        vt[0] = '{16'hA5,   8, 1, 0, 0, 0, 1, 434, 32'hA5,   0, 0};
        vt[1] = '{16'h3C,   8, 1, 0, 1, 0, 1, 434, 32'h3C,   1, 0};
        vt[2] = '{16'h01,   8, 1, 0, 0, 1, 1, 434, 32'h01,   0, 1};
        vt[3] = '{16'h02,   8, 1, 0, 0, 0, 1, 434, 32'h02,   0, 0};
        vt[4] = '{16'h0000, 0, 1, 1, 0, 0, 0, 20,  32'h0,    0, 0};
        vt[5] = '{16'hBEEF, 15, 0, 0, 0, 0, 3, 2,  32'h3EEF, 0, 0};
        vt[6] = '{16'h0007, 5, 1, 1, 1, 0, 0, 0,   32'h07,   1, 0};
        vt[7] = '{16'hFFFF, 7, 0, 0, 0, 1, 2, 9,   32'h7F,   0, 1};

        idle(3);
        chk("reset data", 64'(data), 64'(0));
        chk("reset data_valid", 64'(data_valid), 64'(0));
        chk("reset pause_ack", 64'(pause_ack), 64'(0));
        chk("reset error pulses", 64'({parity_error, frame_error, overrun_error}), 64'(0));
        rst = 1'b1;
        idle(4);

        for (int i = 0; i < 8; i++) begin
            b = period_of(vt[i].baud);
            send_frame(vt[i].d, vt[i].len, vt[i].pe, vt[i].ps, vt[i].flip, vt[i].bad,
                       vt[i].sb, vt[i].baud, c0);
            expect_word($sformatf("vec%0d", i), c0, 1 + vt[i].len + (vt[i].pe ? 1 : 0), b,
                        vt[i].ed, vt[i].ep, vt[i].ef, rc);
            idle(2 * b);
        end

        // Short low glitch on the idle line must be rejected at the start-bit centre.
        baud_rate = 434;
        rx = 1'b0; idle(100); rx = 1'b1;
        idle(900);
        chk("glitch no word", 64'(evq.size()), 64'(0));
        send_frame(16'h5A, 8, 1, 0, 0, 0, 1, 40, c0);
        expect_word("after glitch", c0, 10, 40, 32'h5A, 0, 0, rc);
        idle(80);

        // Overrun: consumer stalled, second word dropped.
        data_ready = 1'b0;
        send_frame(16'h11, 8, 1, 0, 0, 0, 1, 40, c0);
        expect_word("ovr first", c0, 10, 40, 32'h11, 0, 0, rc);
        idle(80);
        send_frame(16'h22, 8, 1, 0, 0, 0, 1, 40, c1);
        w = 0;
        while (ovr_cnt == 0 && w < 200) begin idle(1); w++; end
        chk("overrun count", 64'(ovr_cnt), 64'(1));
        chk("overrun timing", 64'(ovr_cyc - c1), 64'(3 + 20 + 10 * 40 + MAJ));
        chk("overrun data held", 64'(data), 64'(32'h11));
        chk("overrun valid held", 64'(data_valid), 64'(1));
        chk("overrun no new word", 64'(evq.size()), 64'(0));
        data_ready = 1'b1;
        idle(1);
        chk("handshake drops valid", 64'(data_valid), 64'(0));
        idle(80);

        // Reset mid-frame discards the held word and the partial frame.
        data_ready = 1'b0;
        send_frame(16'h33, 8, 1, 0, 0, 0, 1, 40, c0);
        expect_word("pre-reset", c0, 10, 40, 32'h33, 0, 0, rc);
        idle(80);
        rx = 1'b0; idle(120);
        rst = 1'b0; idle(2);
        chk("mid-frame reset data", 64'(data), 64'(0));
        chk("mid-frame reset valid", 64'(data_valid), 64'(0));
        rx = 1'b1; rst = 1'b1; data_ready = 1'b1;
        idle(80);
        send_frame(16'hC3, 8, 1, 0, 0, 0, 1, 40, c0);
        expect_word("post-reset", c0, 10, 40, 32'hC3, 0, 0, rc);
        idle(80);

        // Pause: in-progress frame completes, frames while paused are ignored.
        fork
            send_frame(16'h55, 8, 1, 0, 0, 0, 1, 40, c0);
            begin
                repeat (200) @(posedge clk); #1;
                pause_req = 1'b1;
                repeat (5) @(posedge clk); #1;
                chk("pause_ack low mid-frame", 64'(pause_ack), 64'(0));
            end
        join
        expect_word("pause frame", c0, 10, 40, 32'h55, 0, 0, rc);
        w = 0;
        while (!pause_ack && w < 20) begin idle(1); w++; end
        chk("pause_ack after frame", 64'(ack_cyc - rc), 64'(1));
        send_frame(16'h77, 8, 1, 0, 0, 0, 1, 40, c0);
        idle(80);
        chk("paused frame ignored", 64'(evq.size()), 64'(0));
        chk("pause_ack held", 64'(pause_ack), 64'(1));
        pause_req = 1'b0;
        idle(1);
        chk("pause_ack release", 64'(pause_ack), 64'(0));
        send_frame(16'h66, 8, 1, 0, 0, 0, 1, 40, c0);
        expect_word("after pause", c0, 10, 40, 32'h66, 0, 0, rc);
        idle(80);

        // Randomized frames against the frame-level model.
        for (int n = 0; n < 120; n++) begin
            int baud, sb;
            bit ps;
            d    = 16'($urandom);
            len  = int'($urandom_range(0, 15));
            pe   = 1'($urandom_range(0, 1));
            ps   = 1'($urandom_range(0, 1));
            flip = pe && ($urandom_range(0, 7) == 0);
            bad  = ($urandom_range(0, 7) == 0);
            sb   = int'($urandom_range(0, 3));
            baud = int'($urandom_range(0, 12));
            b    = period_of(baud);
            send_frame(d, len, pe, ps, flip, bad, sb, baud, c0);
            expect_word($sformatf("rand%0d", n), c0, 1 + len + (pe ? 1 : 0), b,
                        DW'(d & 16'((1 << len) - 1)), flip, bad, rc);
            idle(2 * b + 4);
        end

        chk("stray error pulses", 64'(stray_cnt), 64'(0));
        chk("total overruns", 64'(ovr_cnt), 64'(1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
